// File: rtl/alu_ctrl_sequencer_pkg.sv
// Shared types and constants for the ALU control sequencer.
// No logic; pure definitions.
// No flow control.
package alu_ctrl_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } seq_state_t;

    // Instruction opcodes (instr[15:12])
    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_INC   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_DEC   = 4'h3;
    localparam logic [3:0] OP_NEG   = 4'h4;
    localparam logic [3:0] OP_ZERO  = 4'h5;
    localparam logic [3:0] OP_PASSA = 4'h6;
    localparam logic [3:0] OP_NOTA  = 4'h7;
    localparam logic [3:0] OP_AND   = 4'h8;
    localparam logic [3:0] OP_OR    = 4'h9;
    localparam logic [3:0] OP_XOR   = 4'hA;
    localparam logic [3:0] OP_ONES  = 4'hB;
    localparam logic [3:0] OP_SHR   = 4'hC;
    localparam logic [3:0] OP_SHL   = 4'hD;
    localparam logic [3:0] OP_SHRF  = 4'hE;
    localparam logic [3:0] OP_HALT  = 4'hF;

    // ALU operation codes
    localparam logic [4:0] OC_ADD   = 5'b10100;
    localparam logic [4:0] OC_INC   = 5'b10000;
    localparam logic [4:0] OC_SUB   = 5'b10110;
    localparam logic [4:0] OC_DEC   = 5'b10010;
    localparam logic [4:0] OC_NEG   = 5'b10001;
    localparam logic [4:0] OC_ZERO  = 5'b00000;
    localparam logic [4:0] OC_PASSA = 5'b01010;
    localparam logic [4:0] OC_NOTA  = 5'b00101;
    localparam logic [4:0] OC_AND   = 5'b01000;
    localparam logic [4:0] OC_OR    = 5'b01110;
    localparam logic [4:0] OC_XOR   = 5'b00110;
    localparam logic [4:0] OC_ONES  = 5'b01111;
    localparam logic [4:0] OC_SHR   = 5'b11001;
    localparam logic [4:0] OC_SHL   = 5'b11000;

endpackage

// File: rtl/alu_ctrl_sequencer_alu_op_decode.sv
// Maps a 4-bit instruction opcode to the ALU {oc, c0} pair and flags HALT.
// Purely combinational, zero latency.
// No flow control.
module alu_op_decode
    import alu_ctrl_sequencer_pkg::*;
(
    input  logic [3:0] op,
    output logic [4:0] oc,
    output logic       c0,
    output logic       is_halt
);

    // Opcode lookup; HALT leaves oc/c0 at ZERO since they are never latched for it
    always_comb begin
        oc      = OC_ZERO;
        c0      = 1'b0;
        is_halt = 1'b0;
        unique case (op)
            OP_ADD:   oc = OC_ADD;
            OP_INC:   begin oc = OC_INC; c0 = 1'b1; end
            OP_SUB:   begin oc = OC_SUB; c0 = 1'b1; end
            OP_DEC:   oc = OC_DEC;
            OP_NEG:   begin oc = OC_NEG; c0 = 1'b1; end
            OP_ZERO:  oc = OC_ZERO;
            OP_PASSA: oc = OC_PASSA;
            OP_NOTA:  oc = OC_NOTA;
            OP_AND:   oc = OC_AND;
            OP_OR:    oc = OC_OR;
            OP_XOR:   oc = OC_XOR;
            OP_ONES:  oc = OC_ONES;
            OP_SHR:   oc = OC_SHR;
            OP_SHL:   oc = OC_SHL;
            OP_SHRF:  begin oc = OC_SHR; c0 = 1'b1; end
            OP_HALT:  is_halt = 1'b1;
            default:  is_halt = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB control unit driving ALU opcode and register file.
// instr_valid to rf_we is 3 cycles; 4 cycles per instruction with zero-wait memory.
// Holds instr_req and pc stable in FETCH until instr_valid; no other backpressure.
module alu_ctrl_sequencer
    import alu_ctrl_sequencer_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              RF_AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             instr_req,
    output logic [PC_W-1:0]  pc,
    input  logic             instr_valid,
    input  logic [15:0]      instr,
    output logic [RF_AW-1:0] rf_ra,
    output logic [RF_AW-1:0] rf_rb,
    output logic [RF_AW-1:0] rf_wa,
    output logic             rf_we,
    output logic [4:0]       alu_oc,
    output logic             alu_c0,
    output logic             busy,
    output logic             halted
);

    seq_state_t state, state_nxt;
    logic [15:0] ir;
    logic [4:0]  dec_oc;
    logic        dec_c0;
    logic        dec_halt;
    logic        ir_unused;

    assign ir_unused = ^ir[2:0];

    alu_op_decode u_dec (
        .op      (ir[15:12]),
        .oc      (dec_oc),
        .c0      (dec_c0),
        .is_halt (dec_halt)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state selection; start is only honoured from IDLE or HALT
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (start) state_nxt = ST_FETCH;
            ST_FETCH:  if (instr_valid) state_nxt = ST_DECODE;
            ST_DECODE: state_nxt = dec_halt ? ST_HALT : ST_EXEC;
            ST_EXEC:   state_nxt = ST_WB;
            ST_WB:     state_nxt = ST_FETCH;
            ST_HALT:   if (start) state_nxt = ST_FETCH;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Program counter and instruction register; pc wraps naturally at 2^PC_W
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
            ir <= '0;
        end else if ((state == ST_IDLE || state == ST_HALT) && start) begin
            pc <= RESET_PC;
        end else if (state == ST_FETCH && instr_valid) begin
            pc <= pc + PC_W'(1);
            ir <= instr;
        end
    end

    // ALU controls latch on the DECODE->EXEC transition and hold until the next one
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_oc <= OC_ZERO;
            alu_c0 <= 1'b0;
        end else if (state == ST_DECODE && !dec_halt) begin
            alu_oc <= dec_oc;
            alu_c0 <= dec_c0;
        end
    end

    assign instr_req = (state == ST_FETCH);
    assign rf_we     = (state == ST_WB);
    assign halted    = (state == ST_HALT);
    assign busy      = (state != ST_IDLE) && (state != ST_HALT);
    assign rf_ra     = RF_AW'(ir[11:9]);
    assign rf_rb     = RF_AW'(ir[8:6]);
    assign rf_wa     = RF_AW'(ir[5:3]);

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
module tb_alu_ctrl_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, instr_valid;
    logic [15:0] instr;
    logic        instr_req, rf_we, alu_c0, busy, halted;
    logic [15:0] pc;
    logic [2:0]  rf_ra, rf_rb, rf_wa;
    logic [4:0]  alu_oc;

    logic        w_rst, w_start, w_req, w_we, w_c0, w_busy, w_halted;
    logic [15:0] w_pc;
    logic [2:0]  w_ra, w_rb, w_wa;
    logic [4:0]  w_oc;

    alu_ctrl_sequencer #(.PC_W(16), .RESET_PC(16'h0000), .RF_AW(3)) dut (
        .clk(clk), .rst(rst), .start(start), .instr_req(instr_req), .pc(pc),
        .instr_valid(instr_valid), .instr(instr), .rf_ra(rf_ra), .rf_rb(rf_rb),
        .rf_wa(rf_wa), .rf_we(rf_we), .alu_oc(alu_oc), .alu_c0(alu_c0),
        .busy(busy), .halted(halted)
    );

    // Second instance starting at the top of the address space to see the wrap
    alu_ctrl_sequencer #(.PC_W(16), .RESET_PC(16'hFFFF), .RF_AW(3)) u_wrap (
        .clk(clk), .rst(w_rst), .start(w_start), .instr_req(w_req), .pc(w_pc),
        .instr_valid(1'b1), .instr(16'h0000), .rf_ra(w_ra), .rf_rb(w_rb),
        .rf_wa(w_wa), .rf_we(w_we), .alu_oc(w_oc), .alu_c0(w_c0),
        .busy(w_busy), .halted(w_halted)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] op;
        logic [4:0] oc;
        logic       c0;
    } map_vec_t;

    map_vec_t    vec [16];
    logic [15:0] exp_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction starting from FETCH; waits = cycles before instr_valid
    task automatic run_instr(input logic [15:0] ins, input int waits);
        logic [3:0] op;
        op = ins[15:12];
        chk("fetch_req", 32'(instr_req), 32'd1);
        chk("fetch_pc", 32'(pc), 32'(exp_pc));
        for (int w = 0; w < waits; w++) begin
            instr_valid = 1'b0;
            start = (w == 1);
            step();
            start = 1'b0;
            chk("wait_req", 32'(instr_req), 32'd1);
            chk("wait_pc", 32'(pc), 32'(exp_pc));
            chk("wait_we", 32'(rf_we), 32'd0);
        end
        instr = ins;
        instr_valid = 1'b1;
        step();
        exp_pc = exp_pc + 16'd1;
        instr = 16'($urandom);
        instr_valid = 1'($urandom);
        chk("dec_we", 32'(rf_we), 32'd0);
        chk("dec_ra", 32'(rf_ra), 32'(ins[11:9]));
        chk("dec_rb", 32'(rf_rb), 32'(ins[8:6]));
        chk("dec_wa", 32'(rf_wa), 32'(ins[5:3]));
        chk("dec_pc", 32'(pc), 32'(exp_pc));
        step();
        if (op == 4'hF) begin
            chk("halt_flag", 32'(halted), 32'd1);
            chk("halt_busy", 32'(busy), 32'd0);
            chk("halt_we", 32'(rf_we), 32'd0);
        end else begin
            chk("exec_oc", 32'(alu_oc), 32'(vec[op].oc));
            chk("exec_c0", 32'(alu_c0), 32'(vec[op].c0));
            chk("exec_we", 32'(rf_we), 32'd0);
            step();
            chk("wb_we", 32'(rf_we), 32'd1);
            chk("wb_wa", 32'(rf_wa), 32'(ins[5:3]));
            chk("wb_oc", 32'(alu_oc), 32'(vec[op].oc));
            chk("wb_c0", 32'(alu_c0), 32'(vec[op].c0));
            step();
            chk("ret_we", 32'(rf_we), 32'd0);
            chk("ret_req", 32'(instr_req), 32'd1);
        end
        instr_valid = 1'b0;
    endtask

    logic [15:0] r;

    initial begin
        vec[0]  = '{4'h0, 5'b10100, 1'b0};
        vec[1]  = '{4'h1, 5'b10000, 1'b1};
        vec[2]  = '{4'h2, 5'b10110, 1'b1};
        vec[3]  = '{4'h3, 5'b10010, 1'b0};
        vec[4]  = '{4'h4, 5'b10001, 1'b1};
        vec[5]  = '{4'h5, 5'b00000, 1'b0};
        vec[6]  = '{4'h6, 5'b01010, 1'b0};
        vec[7]  = '{4'h7, 5'b00101, 1'b0};
        vec[8]  = '{4'h8, 5'b01000, 1'b0};
        vec[9]  = '{4'h9, 5'b01110, 1'b0};
        vec[10] = '{4'hA, 5'b00110, 1'b0};
        vec[11] = '{4'hB, 5'b01111, 1'b0};
        vec[12] = '{4'hC, 5'b11001, 1'b0};
        vec[13] = '{4'hD, 5'b11000, 1'b0};
        vec[14] = '{4'hE, 5'b11001, 1'b1};
        vec[15] = '{4'hF, 5'b00000, 1'b0};

        rst = 1'b1; start = 1'b0; instr_valid = 1'b0; instr = 16'h0;
        w_rst = 1'b1; w_start = 1'b0;
        step();
        step();
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req", 32'(instr_req), 32'd0);
        chk("rst_we", 32'(rf_we), 32'd0);
        chk("rst_oc", 32'(alu_oc), 32'd0);
        chk("rst_c0", 32'(alu_c0), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_rf", 32'({rf_ra, rf_rb, rf_wa}), 32'd0);
        rst = 1'b0;
        w_rst = 1'b0;

        // Single ADD, zero-wait
        start = 1'b1; step(); start = 1'b0;
        exp_pc = 16'h0000;
        run_instr(16'h0A18, 0);

        // Map sweep from a fresh start: opcodes 0..E back-to-back
        rst = 1'b1; step(); rst = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        exp_pc = 16'h0000;
        for (int i = 0; i < 15; i++) begin
            r = 16'($urandom);
            r[15:12] = vec[i].op;
            run_instr(r, 0);
        end
        chk("sweep_pc", 32'(pc), 32'd15);

        // Wait states, with a start pulse that must be ignored
        run_instr(16'h2B70, 5);

        // Randomized instructions and wait states
        for (int i = 0; i < 40; i++) begin
            r = 16'($urandom);
            r[15:12] = 4'($urandom_range(0, 14));
            run_instr(r, int'($urandom_range(0, 3)));
        end

        // HALT, then restart from pc 0
        run_instr(16'hF000, 0);
        for (int i = 0; i < 3; i++) begin
            instr_valid = 1'b1;
            step();
            chk("halt_stay", 32'(halted), 32'd1);
            chk("halt_nowe", 32'(rf_we), 32'd0);
        end
        instr_valid = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        exp_pc = 16'h0000;
        chk("restart_pc", 32'(pc), 32'd0);
        run_instr(16'h9248, 1);

        // Reset while in EXEC aborts without a write
        instr = 16'h1238; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step();
        chk("abort_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_idle", 32'(busy), 32'd0);
        chk("abort_we", 32'(rf_we), 32'd0);
        chk("abort_oc", 32'(alu_oc), 32'd0);
        chk("abort_pc", 32'(pc), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("abort_quiet", 32'({rf_we, busy}), 32'd0);
        end

        // rst wins over start
        rst = 1'b1; start = 1'b1;
        step();
        rst = 1'b0; start = 1'b0;
        chk("rst_start", 32'(busy), 32'd0);

        // pc wraps from FFFF to 0000 after a fetch
        w_start = 1'b1; step(); w_start = 1'b0;
        chk("wrap_req", 32'(w_req), 32'd1);
        chk("wrap_pre", 32'(w_pc), 32'hFFFF);
        step();
        chk("wrap_post", 32'(w_pc), 32'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
